mips_multicycle_ctrl: RTL and testbench

//  Multi-cycle MIPS-subset core controller: fetch -> decode -> execute -> mem -> writeback FSM.

---
 rtl/mips_multicycle_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS-subset core controller: FETCH -> DECODE -> EXEC -> MEM -> WB FSM.
// Owns PC, IR, A/B/ALUOut/MDR holding registers and a 32x32 register file ($0 reads as 0).
// Ports: clk/reset (sync, active-high), run; imem req/addr/rdata/valid; dmem req/we/addr/wdata/rdata/valid;
//        pc, result/result_valid (writeback pulse), halted/err (sticky until reset).
module mips_multicycle_ctrl #(
    parameter int unsigned IMEM_AW     = 8,
    parameter int unsigned DMEM_AW     = 8,
    parameter logic [31:0] RESET_PC    = 32'h0,
    parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               imem_valid,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [31:0]        dmem_wdata,
    input  logic [31:0]        dmem_rdata,
    input  logic               dmem_valid,
    output logic [31:0]        pc,
    output logic [31:0]        result,
    output logic               result_valid,
    output logic               halted,
    output logic               err
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] aluout_q, aluout_d;
    logic [31:0] mdr_q, mdr_d;
    logic [31:0] result_q, result_d;
    logic        err_q, err_d;
    logic [31:0] regs_q [32];

    // Instruction fields
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] imm_sext;
    logic        legal;
    logic [31:0] alu_res;
    logic [31:0] br_target;
    logic [31:0] wb_value;
    logic [4:0]  wb_dst;
    logic        rf_we;

    always_comb begin
        op        = ir_q[31:26];
        rs        = ir_q[25:21];
        rt        = ir_q[20:16];
        rd        = ir_q[15:11];
        shamt     = ir_q[10:6];
        funct     = ir_q[5:0];
        imm_sext  = {{16{ir_q[15]}}, ir_q[15:0]};
        legal     = ((op == OP_RTYPE) &&
                     (funct inside {FN_SLL, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT})) ||
                    (op inside {OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_LW, OP_SW});
        // pc_q already points past the branch by the time EXEC runs.
        br_target = pc_q + {imm_sext[29:0], 2'b00};
        wb_value  = (op == OP_LW) ? mdr_q : aluout_q;
        wb_dst    = (op == OP_RTYPE) ? rd : rt;

        alu_res = a_q + imm_sext;
        if (op == OP_RTYPE) begin
            case (funct)
                FN_ADD:  alu_res = a_q + b_q;
                FN_SUB:  alu_res = a_q - b_q;
                FN_AND:  alu_res = a_q & b_q;
                FN_OR:   alu_res = a_q | b_q;
                FN_SLT:  alu_res = {31'd0, $signed(a_q) < $signed(b_q)};
                FN_SLL:  alu_res = b_q << shamt;
                default: alu_res = 32'd0;
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        a_d          = a_q;
        b_d          = b_q;
        aluout_d     = aluout_q;
        mdr_d        = mdr_q;
        result_d     = result_q;
        err_d        = err_q;
        rf_we        = 1'b0;
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        result_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    ir_d    = imem_rdata;
                    pc_d    = pc_q + 32'd4;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d = regs_q[rs];
                b_d = regs_q[rt];
                // Halt opcode is checked first so it wins even if it aliases a real opcode.
                if (op == HALT_OPCODE) begin
                    err_d   = 1'b0;
                    state_d = S_HALT;
                end else if (!legal) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                aluout_d = alu_res;
                case (op)
                    OP_BEQ: begin
                        if (a_q == b_q) pc_d = br_target;
                        state_d = S_FETCH;
                    end
                    OP_BNE: begin
                        if (a_q != b_q) pc_d = br_target;
                        state_d = S_FETCH;
                    end
                    OP_J: begin
                        pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
                        state_d = S_FETCH;
                    end
                    OP_LW, OP_SW: state_d = S_MEM;
                    default:      state_d = S_WB;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (op == OP_SW);
                if (dmem_valid) begin
                    if (op == OP_SW) begin
                        state_d = S_FETCH;
                    end else begin
                        mdr_d   = dmem_rdata;
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we        = (wb_dst != 5'd0);
                result_d     = wb_value;
                result_valid = 1'b1;
                state_d      = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            ir_q     <= 32'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            aluout_q <= 32'd0;
            mdr_q    <= 32'd0;
            result_q <= 32'd0;
            err_q    <= 1'b0;
            for (int i = 0; i < 32; i++) regs_q[i] <= 32'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluout_q <= aluout_d;
            mdr_q    <= mdr_d;
            result_q <= result_d;
            err_q    <= err_d;
            if (rf_we) regs_q[wb_dst] <= wb_value;
        end
    end

    assign imem_addr  = pc_q[IMEM_AW+1:2];
    assign dmem_addr  = aluout_q[DMEM_AW+1:2];
    assign dmem_wdata = b_q;
    assign pc         = pc_q;
    // Present the value being written back in the same cycle as the pulse.
    assign result     = (state_q == S_WB) ? wb_value : result_q;
    assign halted     = (state_q == S_HALT);
    assign err        = err_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
module tb_mips_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset, run;
    logic        imem_req, imem_valid;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        dmem_req, dmem_we, dmem_valid;
    logic [7:0]  dmem_addr;
    logic [31:0] dmem_wdata, dmem_rdata;
    logic [31:0] pc, result;
    logic        result_valid, halted, err;

    always #5 clk = ~clk;

    mips_multicycle_ctrl dut (
        .clk(clk), .reset(reset), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_valid(dmem_valid),
        .pc(pc), .result(result), .result_valid(result_valid), .halted(halted), .err(err)
    );

    localparam logic [31:0] HALT_W = 32'hFC00_0000;

    int n_chk = 0;
    int n_fail = 0;
    int wi, wd;

    logic [31:0] imem [0:255];
    logic [31:0] dmem [0:255];

    // Reference-model expectations
    int          exp_wb_cyc_q[$];
    logic [31:0] exp_wb_val_q[$];
    logic [7:0]  exp_fetch_q[$];
    logic [7:0]  exp_st_addr_q[$];
    logic [31:0] exp_st_dat_q[$];
    int          exp_halt_cyc;
    logic        exp_err;
    logic [31:0] exp_last_result, exp_pc;

    // Observations for directed constant checks
    int          got_wb_cyc_q[$];
    logic [31:0] got_wb_val_q[$];
    logic [7:0]  got_fetch_q[$];
    logic [7:0]  got_st_addr;
    logic [31:0] got_st_dat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input int rd, input int rs, input int rt, input int sh);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    function automatic logic [31:0] enc_j(input int word_tgt);
        return {6'h02, 26'(word_tgt)};
    endfunction

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = HALT_W;
    endtask

    // ISA-level model: runs the program instruction by instruction and predicts
    // fetch addresses, stores, writebacks with their cycle, and the halt cycle.
    task automatic model_run();
        logic [31:0] r [32];
        logic [31:0] m [256];
        logic [31:0] mpc, ins, a, b, se, val, ea;
        logic [5:0]  op, fn;
        int          dst, t, twb;
        bit          do_wb;
        exp_wb_cyc_q.delete(); exp_wb_val_q.delete(); exp_fetch_q.delete();
        exp_st_addr_q.delete(); exp_st_dat_q.delete();
        exp_last_result = 32'd0; exp_halt_cyc = -1; exp_err = 1'b0;
        for (int i = 0; i < 32; i++) r[i] = 32'd0;
        for (int i = 0; i < 256; i++) m[i] = dmem[i];
        mpc = 32'd0; t = 0;
        for (int n = 0; n < 300; n++) begin
            ins = imem[mpc[9:2]];
            exp_fetch_q.push_back(mpc[9:2]);
            mpc = mpc + 32'd4;
            op = ins[31:26]; fn = ins[5:0];
            a = r[ins[25:21]]; b = r[ins[20:16]];
            se = {{16{ins[15]}}, ins[15:0]};
            do_wb = 1'b0; dst = int'(ins[20:16]); twb = t + wi + 3; val = 32'd0;
            exp_pc = mpc;
            if (op == 6'h3F) begin
                exp_halt_cyc = t + wi + 2; exp_err = 1'b0; return;
            end
            case (op)
                6'h00: begin
                    dst = int'(ins[15:11]); do_wb = 1'b1;
                    case (fn)
                        6'h20: val = a + b;
                        6'h22: val = a - b;
                        6'h24: val = a & b;
                        6'h25: val = a | b;
                        6'h2A: val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        6'h00: val = b << ins[10:6];
                        default: begin exp_halt_cyc = t + wi + 2; exp_err = 1'b1; return; end
                    endcase
                end
                6'h08: begin val = a + se; do_wb = 1'b1; end
                6'h23: begin ea = a + se; val = m[ea[9:2]]; do_wb = 1'b1; twb = t + wi + 4 + wd; end
                6'h2B: begin
                    ea = a + se; m[ea[9:2]] = b;
                    exp_st_addr_q.push_back(ea[9:2]); exp_st_dat_q.push_back(b);
                    t = t + wi + 4 + wd;
                end
                6'h04: begin if (a == b) mpc = mpc + (se << 2); t = t + wi + 3; end
                6'h05: begin if (a != b) mpc = mpc + (se << 2); t = t + wi + 3; end
                6'h02: begin mpc = {mpc[31:28], ins[25:0], 2'b00}; t = t + wi + 3; end
                default: begin exp_halt_cyc = t + wi + 2; exp_err = 1'b1; return; end
            endcase
            if (do_wb) begin
                exp_wb_cyc_q.push_back(twb); exp_wb_val_q.push_back(val);
                if (dst != 0) r[dst] = val;
                exp_last_result = val;
                t = twb + 1;
            end
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1; run = 1'b0; imem_valid = 1'b0; dmem_valid = 1'b0;
        imem_rdata = 32'd0; dmem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Reset, start, then act as both memories cycle by cycle while scoring the DUT.
    task automatic run_prog(input string tag);
        int icnt, dcnt, halt_seen;
        model_run();
        got_wb_cyc_q.delete(); got_wb_val_q.delete(); got_fetch_q.delete();
        apply_reset();
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        icnt = 0; dcnt = 0; halt_seen = -1;
        for (int cyc = 0; cyc < 5000; cyc++) begin
            if (imem_req) begin
                if (icnt == 0) begin
                    got_fetch_q.push_back(imem_addr);
                    if (exp_fetch_q.size() == 0) chk({tag, " unexpected fetch"}, {24'd0, imem_addr}, 32'hFFFF_FFFF);
                    else chk({tag, " fetch addr"}, {24'd0, imem_addr}, {24'd0, exp_fetch_q.pop_front()});
                end
                if (icnt == wi) begin imem_valid = 1'b1; imem_rdata = imem[imem_addr]; icnt = 0; end
                else begin imem_valid = 1'b0; imem_rdata = $urandom; icnt++; end
            end else begin
                imem_valid = ($urandom_range(0, 3) == 0); imem_rdata = $urandom; icnt = 0;
            end
            if (dmem_req) begin
                if (dcnt == wd) begin
                    dmem_valid = 1'b1; dcnt = 0;
                    if (dmem_we) begin
                        got_st_addr = dmem_addr; got_st_dat = dmem_wdata;
                        if (exp_st_addr_q.size() == 0) chk({tag, " unexpected store"}, {24'd0, dmem_addr}, 32'hFFFF_FFFF);
                        else begin
                            chk({tag, " store addr"}, {24'd0, dmem_addr}, {24'd0, exp_st_addr_q.pop_front()});
                            chk({tag, " store data"}, dmem_wdata, exp_st_dat_q.pop_front());
                        end
                        dmem[dmem_addr] = dmem_wdata;
                    end else begin
                        dmem_rdata = dmem[dmem_addr];
                    end
                end else begin
                    dmem_valid = 1'b0; dmem_rdata = $urandom; dcnt++;
                end
            end else begin
                dmem_valid = ($urandom_range(0, 3) == 0); dmem_rdata = $urandom; dcnt = 0;
            end
            if (result_valid) begin
                got_wb_cyc_q.push_back(cyc); got_wb_val_q.push_back(result);
                if (exp_wb_val_q.size() == 0) chk({tag, " unexpected writeback"}, result, 32'hXXXX_XXXX);
                else begin
                    chk({tag, " wb value"}, result, exp_wb_val_q.pop_front());
                    chk({tag, " wb cycle"}, 32'(cyc), 32'(exp_wb_cyc_q.pop_front()));
                end
            end
            if (halted && halt_seen < 0) begin
                halt_seen = cyc;
                chk({tag, " halt cycle"}, 32'(cyc), 32'(exp_halt_cyc));
                chk({tag, " err"}, {31'd0, err}, {31'd0, exp_err});
                chk({tag, " pc at halt"}, pc, exp_pc);
                chk({tag, " result at halt"}, result, exp_last_result);
            end
            if (halt_seen >= 0) begin
                chk({tag, " no req in halt"}, {30'd0, imem_req, dmem_req}, 32'd0);
                if (cyc >= halt_seen + 4) break;
            end
            @(negedge clk);
        end
        imem_valid = 1'b0; dmem_valid = 1'b0;
        if (halt_seen < 0) chk({tag, " timeout before halt"}, 32'd0, 32'd1);
        chk({tag, " missing writebacks"}, 32'(exp_wb_val_q.size()), 32'd0);
        chk({tag, " missing stores"}, 32'(exp_st_addr_q.size()), 32'd0);
    endtask

    task automatic gen_prog(input int n);
        logic [5:0] fns [6];
        int kind, ra, rb, rc, off;
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
        clear_imem();
        for (int k = 0; k < n; k++) begin
            kind = (k < 3) ? 0 : $urandom_range(0, 9);
            ra = $urandom_range(0, 7); rb = $urandom_range(0, 7); rc = $urandom_range(0, 7);
            off = $urandom_range(0, 3);
            if (k + 1 + off > n) off = n - k - 1;
            case (kind)
                0, 1:    imem[k] = enc_i(6'h08, rc, ra, 16'($urandom));
                2, 3, 4: imem[k] = enc_r(fns[$urandom_range(0, 5)], rc, ra, rb, $urandom_range(0, 31));
                5:       imem[k] = enc_i(6'h23, rc, ra, 16'($urandom));
                6:       imem[k] = enc_i(6'h2B, rb, ra, 16'($urandom));
                7:       imem[k] = enc_i(6'h04, rb, ra, 16'(off));
                8:       imem[k] = enc_i(6'h05, rb, ra, 16'(off));
                default: imem[k] = enc_j(k + 1 + off);
            endcase
        end
        case ($urandom_range(0, 3))
            0:       imem[n] = 32'hF800_0000;                  // opcode 3Eh
            1:       imem[n] = enc_r(6'h21, 1, 2, 3, 0);       // unsupported funct
            default: imem[n] = HALT_W;
        endcase
    endtask

    initial begin
        for (int i = 0; i < 256; i++) dmem[i] = $urandom;
        clear_imem();

        // Reset state
        apply_reset();
        chk("reset pc", pc, 32'd0);
        chk("reset reqs", {29'd0, imem_req, dmem_req, dmem_we}, 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset flags", {29'd0, result_valid, halted, err}, 32'd0);

        // addi/addi/add back-to-back writebacks
        wi = 0; wd = 0; clear_imem();
        imem[0] = enc_i(6'h08, 1, 0, 16'd5);
        imem[1] = enc_i(6'h08, 2, 0, 16'hFFFD);
        imem[2] = enc_r(6'h20, 3, 1, 2, 0);
        run_prog("p1");
        chk("p1 wb0", got_wb_val_q[0], 32'd5);
        chk("p1 wb1", got_wb_val_q[1], 32'hFFFF_FFFD);
        chk("p1 wb2", got_wb_val_q[2], 32'd2);
        chk("p1 add gap", 32'(got_wb_cyc_q[2] - got_wb_cyc_q[1]), 32'd4);

        // sw then lw with 2-cycle data memory
        wi = 0; wd = 2; clear_imem();
        imem[0] = enc_i(6'h08, 3, 0, 16'd2);
        imem[1] = enc_i(6'h2B, 3, 0, 16'd8);
        imem[2] = enc_i(6'h23, 4, 0, 16'd8);
        run_prog("p2");
        chk("p2 st addr", {24'd0, got_st_addr}, 32'd2);
        chk("p2 st data", got_st_dat, 32'd2);
        chk("p2 lw value", got_wb_val_q[1], 32'd2);
        // lw starts at cycle 10 (addi 0-3, sw 4-9) and spans 7 cycles
        chk("p2 lw retire", 32'(got_wb_cyc_q[1]), 32'd16);

        // beq taken, bne not taken, j
        wi = 1; wd = 0; clear_imem();
        imem[0] = enc_i(6'h04, 1, 1, 16'd2);
        imem[3] = enc_i(6'h05, 0, 0, 16'd5);
        imem[4] = enc_j(32'h10);
        run_prog("p3");
        chk("p3 fetch1", {24'd0, got_fetch_q[1]}, 32'd3);
        chk("p3 fetch2", {24'd0, got_fetch_q[2]}, 32'd4);
        chk("p3 fetch3", {24'd0, got_fetch_q[3]}, 32'h10);

        // write to $0 is reported but discarded
        wi = 0; wd = 0; clear_imem();
        imem[0] = enc_i(6'h08, 0, 0, 16'd7);
        imem[1] = enc_r(6'h22, 5, 0, 0, 0);
        run_prog("p4");
        chk("p4 wb0", got_wb_val_q[0], 32'd7);
        chk("p4 r0 reads 0", got_wb_val_q[1], 32'd0);

        // halt vs illegal opcode
        clear_imem();
        run_prog("p5a");
        chk("p5a halted/err", {30'd0, halted, err}, 32'd2);
        imem[0] = 32'hF800_0000;
        run_prog("p5b");
        chk("p5b halted/err", {30'd0, halted, err}, 32'd3);

        // reset while a load is waiting on data memory
        wi = 0; clear_imem();
        imem[0] = enc_i(6'h23, 1, 0, 16'd8);
        apply_reset();
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        for (int c = 0; c < 20 && !dmem_req; c++) begin
            imem_valid = imem_req; imem_rdata = imem[imem_addr];
            @(negedge clk);
        end
        imem_valid = 1'b0;
        chk("p6 reached mem", {31'd0, dmem_req}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("p6 req dropped", {29'd0, dmem_req, dmem_we, imem_req}, 32'd0);
        chk("p6 pc reset", pc, 32'd0);
        reset = 1'b0; dmem_valid = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("p6 no late wb", {31'd0, result_valid}, 32'd0);
            chk("p6 result", result, 32'd0);
        end
        dmem_valid = 1'b0;

        // random programs with random memory wait states
        for (int p = 0; p < 12; p++) begin
            wi = $urandom_range(0, 2); wd = $urandom_range(0, 2);
            gen_prog(24);
            run_prog($sformatf("rand%0d", p));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
